// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch-side PC stage: PCSrc encodings and PC FSM states.
package pc_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_ALU  = 2'b10;
  localparam logic [1:0] PCSRC_HOLD = 2'b11;

  typedef enum logic [1:0] {
    PC_ST_BOOT = 2'b00,
    PC_ST_RUN  = 2'b01,
    PC_ST_HALT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux and next-state logic for pc_unit.
// Optional build macro: PC_MISALIGN_TRAP_EN (misaligned redirect halts instead of truncating).
//
// state      | meaning
// -----------+------------------------------------------------------------
// PC_ST_BOOT | first cycle after reset, no fetch request
// PC_ST_RUN  | fetching; PC advances, holds or redirects
// PC_ST_HALT | sticky stop, no fetch; only reset leaves it
module pc_next_sel
  import pc_unit_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int INST_BYTES = 4
) (
  input  pc_state_e         state,
  input  logic [1:0]        PCSrc,
  input  logic              ExValid,
  input  logic              Stall,
  input  logic              FetchReady,
  input  logic [ADDR_W-1:0] BrTarget,
  input  logic [ADDR_W-1:0] AluTarget,
  input  logic [ADDR_W-1:0] pc,
  output pc_state_e         state_next,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc_plus,
`ifdef PC_MISALIGN_TRAP_EN
  output logic              misalign_set,
`endif
  output logic              flush
);

  logic              redirect;
  logic              halt_req;
  logic [ADDR_W-1:0] target;

  assign pc_plus = pc + ADDR_W'(INST_BYTES);

  // Decode the EX-stage request; PCSrc means nothing while ExValid is low.
  always_comb begin
    redirect = 1'b0;
    halt_req = 1'b0;
    target   = AluTarget;
    case (PCSrc)
      PCSRC_SEQ:  ;
      PCSRC_BR: begin
        redirect = ExValid;
        target   = BrTarget;
      end
      PCSRC_ALU:  redirect = ExValid;
      PCSRC_HOLD: halt_req = ExValid;
      default:    ;
    endcase
  end

  // Priority: halt request, redirect, stall, memory back-pressure, sequential.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    flush      = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_set = 1'b0;
`endif
    case (state)
      PC_ST_BOOT: state_next = PC_ST_RUN;
      PC_ST_RUN: begin
        flush = redirect | halt_req;
        if (halt_req) begin
          state_next = PC_ST_HALT;
        end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (target[1:0] != 2'b00) begin
            state_next   = PC_ST_HALT;
            misalign_set = 1'b1;
          end else begin
            pc_next = target;
          end
`else
          pc_next = target & ~ADDR_W'(3);
`endif
        end else if (!Stall && FetchReady) begin
          pc_next = pc_plus;
        end
      end
      PC_ST_HALT: ;
      default:    state_next = PC_ST_BOOT;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-side program-counter stage: holds fetch PC and FSM state, drives the
// fetch request and the wrong-path flush of IF/ID and ID/EX.
// Optional build macro: PC_MISALIGN_TRAP_EN (adds sticky Misalign output).
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int               INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        PCSrc,
  input  logic              ExValid,
  input  logic [ADDR_W-1:0] BrTarget,
  input  logic [ADDR_W-1:0] AluTarget,
  input  logic              Stall,
  input  logic              FetchReady,
  output logic              FetchValid,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              FlushIF,
  output logic              FlushID,
`ifdef PC_MISALIGN_TRAP_EN
  output logic              Misalign,
`endif
  output logic              Halted
);

  pc_state_e         state;
  pc_state_e         state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              flush;
`ifdef PC_MISALIGN_TRAP_EN
  logic              misalign_set;
`endif

  pc_next_sel #(
    .ADDR_W     (ADDR_W),
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .state      (state),
    .PCSrc      (PCSrc),
    .ExValid    (ExValid),
    .Stall      (Stall),
    .FetchReady (FetchReady),
    .BrTarget   (BrTarget),
    .AluTarget  (AluTarget),
    .pc         (PC),
    .state_next (state_next),
    .pc_next    (pc_next),
    .pc_plus    (PCPlus4),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign_set (misalign_set),
`endif
    .flush      (flush)
  );

  // State and PC registers; reset drops any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PC_ST_BOOT;
      PC    <= RESET_PC;
    end else begin
      state <= state_next;
      PC    <= pc_next;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)               Misalign <= 1'b0;
    else if (misalign_set) Misalign <= 1'b1;
  end
`endif

  assign FetchValid = (state == PC_ST_RUN);
  assign Halted     = (state == PC_ST_HALT);
  // Flush must not fire while reset is held, even if EX shows a redirect.
  assign FlushIF    = flush & ~rst;
  assign FlushID    = flush & ~rst;

endmodule
